// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake bundle with payload and control lane.
//   valid : producer offers an entry
//   ready : consumer can accept
//   data  : DATA_W-bit payload
//   ctrl  : CTRL_W-bit control lane
// master = producer side, slave = consumer side.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 2
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake and a
// 2-entry skid buffer. up.ready comes straight from a flop, so there is no
// combinational path from dn.ready back upstream.
// Ports:
//   clock, nreset : clock, synchronous active-low reset
//   flush         : synchronous squash of all stored entries
//   up (slave)    : upstream valid/ready/data/ctrl
//   dn (master)   : downstream valid/ready/data/ctrl; ctrl zero on a bubble
//   occupancy     : number of stored entries (0..2)
// Optional feature macro STAGE_PERF_CNT_EN adds saturating counters
//   stall_cycles  : cycles with dn.valid=1 and dn.ready=0
//   bubble_cycles : cycles with dn.valid=0 and dn.ready=1
module pipe_stage_skid #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 2,
  parameter int unsigned BUBBLE_ZERO = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 flush,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn,
  output logic [1:0]           occupancy
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     bubble_cycles
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic main_valid;
  logic skid_valid;
  logic up_xfer;
  logic dn_xfer;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  assign up_xfer    = up.valid & up.ready;
  assign dn_xfer    = main_valid & dn.ready;

  // State and payload registers.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Next-state and load logic; flush discards any incoming entry.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_xfer) begin
            main_data_d = up.data;
            main_ctrl_d = up.ctrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            main_data_d = up.data;
            main_ctrl_d = up.ctrl;
          end else if (dn_xfer) begin
            state_d = EMPTY;
          end else if (up_xfer) begin
            skid_data_d = up.data;
            skid_ctrl_d = up.ctrl;
            state_d     = FULL;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign up.ready  = ~skid_valid;
  assign dn.valid  = main_valid;
  assign dn.ctrl   = main_valid ? main_ctrl_q : '0;
  assign occupancy = state_q;

  if (BUBBLE_ZERO != 0) begin : g_bubble_zero
    assign dn.data = main_valid ? main_data_q : '0;
  end else begin : g_bubble_stale
    assign dn.data = main_data_q;
  end

`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] bubble_cycles_q, bubble_cycles_d;

  // Saturating counters, cleared by reset only.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      stall_cycles_q  <= '0;
      bubble_cycles_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      bubble_cycles_q <= bubble_cycles_d;
    end
  end

  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    bubble_cycles_d = bubble_cycles_q;
    if (main_valid && !dn.ready && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (!main_valid && dn.ready && (bubble_cycles_q != '1)) begin
      bubble_cycles_d = bubble_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed bench for pipe_stage_skid. Instance 0 uses
// BUBBLE_ZERO=1, instance 1 (same stimulus) uses BUBBLE_ZERO=0.
// Observed tuple: {up_ready, occupancy, dn_valid, dn_ctrl, dn_data}.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OBS_W  = 1 + 2 + 1 + CTRL_W + DATA_W;

  logic clock;
  logic nreset;
  logic flush;
  logic [1:0] occ0, occ1;
  logic [CNT_W-1:0] stall0, bubble0, stall1, bubble1;
  int checks;
  int errors;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up0 ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn0 ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up1 ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn1 ();

  assign up1.valid = up0.valid;
  assign up1.data  = up0.data;
  assign up1.ctrl  = up0.ctrl;
  assign dn1.ready = dn0.ready;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_ZERO(1), .CNT_W(CNT_W)) dut0 (
    .clock(clock), .nreset(nreset), .flush(flush), .up(up0), .dn(dn0), .occupancy(occ0)
`ifdef STAGE_PERF_CNT_EN
    , .stall_cycles(stall0), .bubble_cycles(bubble0)
`endif
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_ZERO(0), .CNT_W(CNT_W)) dut1 (
    .clock(clock), .nreset(nreset), .flush(flush), .up(up1), .dn(dn1), .occupancy(occ1)
`ifdef STAGE_PERF_CNT_EN
    , .stall_cycles(stall1), .bubble_cycles(bubble1)
`endif
  );

`ifndef STAGE_PERF_CNT_EN
  assign stall0  = '0;
  assign bubble0 = '0;
  assign stall1  = '0;
  assign bubble1 = '0;
`endif

  logic [OBS_W-1:0] obs0, obs1;
  assign obs0 = {up0.ready, occ0, dn0.valid, dn0.ctrl, dn0.data};
  assign obs1 = {up1.ready, occ1, dn1.valid, dn1.ctrl, dn1.data};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge, then settle away from the edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic r);
    up0.valid = v;
    up0.data  = d;
    up0.ctrl  = c;
    dn0.ready = r;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    flush  = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
`ifdef STAGE_PERF_CNT_EN
    checks++;
    if ({stall0, bubble0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_counters got %h exp %h", {stall0, bubble0}, 8'h00);
    end
`endif
    nreset = 1'b1;
  endtask

  task automatic test_stream;
    logic [DATA_W-1:0] vals [3];
    vals[0] = 32'h11;
    vals[1] = 32'h22;
    vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 2'b01, 1'b1);
      tick();
      checks++;
      if (obs0 !== {1'b1, 2'd1, 1'b1, 2'b01, vals[i]}) begin
        errors++;
        $display("FAIL stream_%0d got %h exp %h", i, obs0, {1'b1, 2'd1, 1'b1, 2'b01, vals[i]});
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL stream_drain got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
  endtask

  task automatic test_backpressure;
    drive(1'b1, 32'hA1, 2'b10, 1'b1);
    tick();
    drive(1'b1, 32'hB2, 2'b01, 1'b0);
    tick();
    checks++;
    if (obs0 !== {1'b0, 2'd2, 1'b1, 2'b10, 32'hA1}) begin
      errors++;
      $display("FAIL bp_full got %h exp %h", obs0, {1'b0, 2'd2, 1'b1, 2'b10, 32'hA1});
    end
    // Offer while full; must not be accepted.
    drive(1'b1, 32'hEE, 2'b11, 1'b0);
    tick();
    checks++;
    if (obs0 !== {1'b0, 2'd2, 1'b1, 2'b10, 32'hA1}) begin
      errors++;
      $display("FAIL bp_hold got %h exp %h", obs0, {1'b0, 2'd2, 1'b1, 2'b10, 32'hA1});
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd1, 1'b1, 2'b01, 32'hB2}) begin
      errors++;
      $display("FAIL bp_second got %h exp %h", obs0, {1'b1, 2'd1, 1'b1, 2'b01, 32'hB2});
    end
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL bp_empty got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
  endtask

  task automatic test_flush;
    drive(1'b1, 32'hAA, 2'b11, 1'b0);
    tick();
    drive(1'b1, 32'hBB, 2'b11, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hCC, 2'b11, 1'b0);
    tick();
    flush = 1'b0;
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL flush_full got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL flush_no_cc got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
    // Flush from ONE while an upstream transfer is accepted: it is discarded.
    drive(1'b1, 32'hDD, 2'b01, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hEE, 2'b01, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL flush_one got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
  endtask

  task automatic test_bubble_ctrl;
    drive(1'b1, 32'h77, 2'b11, 1'b0);
    tick();
    checks++;
    if (obs1 !== {1'b1, 2'd1, 1'b1, 2'b11, 32'h77}) begin
      errors++;
      $display("FAIL bubble_loaded got %h exp %h", obs1, {1'b1, 2'd1, 1'b1, 2'b11, 32'h77});
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL bubble_zero got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
    checks++;
    if (obs1 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h77}) begin
      errors++;
      $display("FAIL bubble_stale got %h exp %h", obs1, {1'b1, 2'd0, 1'b0, 2'b00, 32'h77});
    end
  endtask

  task automatic test_reset_midflight;
    drive(1'b1, 32'h61, 2'b01, 1'b0);
    tick();
    drive(1'b1, 32'h62, 2'b10, 1'b0);
    tick();
    nreset = 1'b0;
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
    checks++;
    if (obs1 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_stale got %h exp %h", obs1, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
    nreset = 1'b1;
    drive(1'b1, 32'h5A, 2'b01, 1'b0);
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd1, 1'b1, 2'b01, 32'h5A}) begin
      errors++;
      $display("FAIL rst_first got %h exp %h", obs0, {1'b1, 2'd1, 1'b1, 2'b01, 32'h5A});
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL rst_alone got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 2'b00, 32'h0});
    end
  endtask

`ifdef STAGE_PERF_CNT_EN
  task automatic test_perf_cnt;
    nreset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    nreset = 1'b1;
    drive(1'b1, 32'h99, 2'b01, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if ({stall0, bubble0} !== {4'hF, 4'h0}) begin
      errors++;
      $display("FAIL perf_sat got %h exp %h", {stall0, bubble0}, {4'hF, 4'h0});
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({stall0, bubble0} !== {4'hF, 4'h0}) begin
      errors++;
      $display("FAIL perf_flush got %h exp %h", {stall0, bubble0}, {4'hF, 4'h0});
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({stall0, bubble0} !== {4'hF, 4'h3}) begin
      errors++;
      $display("FAIL perf_bubble got %h exp %h", {stall0, bubble0}, {4'hF, 4'h3});
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble_ctrl();
    test_reset_midflight();
`ifdef STAGE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the fixed-field stall-driven stage registers between datapath stages.
- Upstream can keep issuing for one cycle after downstream back-pressure, with no combinational ready path upstream.
- A dedicated control lane (register-file write enables and similar) is forced to zero whenever the output is a bubble.
- Synchronous flush kills all in-flight contents for branch and exception squash.

Parameters:
DATA_W, 32, payload width (instruction word, operands, return address packed by the instantiating stage)
CTRL_W, 2, control-lane width; every bit is zeroed on a bubble
BUBBLE_ZERO, 1, 1 = dn_data reads all-zero when dn_valid=0; 0 = dn_data shows the stale main slot
CNT_W, 16, width of the performance counters (used only with the optional feature)

Ports:
clock  in  1  system clock, all state updates on the rising edge
nreset  in  1  synchronous, active-low reset
flush  in  1  synchronous squash of all stored entries
up_valid  in  1  upstream offers an entry
up_ready  out  1  stage can accept; registered (equals !skid_valid)
up_data  in  DATA_W  upstream payload
up_ctrl  in  CTRL_W  upstream control lane
dn_valid  out  1  main slot holds a valid entry
dn_ready  in  1  downstream accepts
dn_data  out  DATA_W  payload from the main slot
dn_ctrl  out  CTRL_W  control lane from the main slot; zero when dn_valid=0
occupancy  out  2  0, 1 or 2 entries stored

Behaviour:
Storage and handshake:
- Two slots: main (drives outputs) and skid. Registered state: main_valid, skid_valid and both payload/ctrl copies.
- up_xfer = up_valid & up_ready.
- dn_xfer = dn_valid & dn_ready.
- dn_valid = main_valid.
- up_ready = !skid_valid. It has no combinational dependence on dn_ready.

States and transitions (priority: reset > flush > normal):
- EMPTY (0 entries):
  - up_xfer -> load main, go to ONE.
- ONE (1 entry):
  - up_xfer & dn_xfer -> load main with new entry, stay in ONE.
  - dn_xfer only -> go to EMPTY.
  - up_xfer only -> load skid, go to FULL.
- FULL (2 entries):
  - up_ready=0, so no upstream transfer is possible.
  - dn_xfer -> skid moves to main, skid_valid=0, go to ONE. up_ready returns high on the next cycle.

Ordering and timing:
- Strict FIFO order.
- Latency is 1 cycle from up_xfer to dn_valid.
- Throughput is 1 entry per cycle while dn_ready=1.

Flush:
- Next edge clears main_valid and skid_valid and sets occupancy to 0.
- Any up_xfer in the same cycle is discarded.
- Any dn_xfer in the same cycle completes normally, because downstream already sampled the entry.
- up_ready is 1 on the following cycle.

Reset:
- All registers go to zero.
- After the reset edge: dn_valid=0, dn_data=0, dn_ctrl=0, occupancy=0, up_ready=1.
- Reset mid-transfer drops all contents, identical to flush.

Outputs when dn_valid=0:
- dn_ctrl is forced to 0 regardless of BUBBLE_ZERO.
- dn_data is 0 if BUBBLE_ZERO=1.

Miscellaneous:
- Payload and ctrl registers are written only on load. They are never cleared on dequeue, except by reset.
- occupancy = main_valid + skid_valid. The encoding 3 is unreachable.

Optional Feature:
Macro: STAGE_PERF_CNT_EN

With the macro defined:
- Adds output stall_cycles[CNT_W]: counts cycles with dn_valid=1 & dn_ready=0.
- Adds output bubble_cycles[CNT_W]: counts cycles with dn_valid=0 & dn_ready=1.
- Both counters saturate at all-ones.
- Both are cleared by nreset only; flush does not clear them.
- Both are 0 after reset.

Without the macro: the ports and logic are absent. Handshake behaviour is identical.

Test Plan:
1. Reset, then stream 0x11,0x22,0x33 with dn_ready=1 -> each appears on dn_data 1 cycle after acceptance; up_ready stays 1; occupancy never exceeds 1.
2. Main holds 0xA1; drop dn_ready while 0xB2 is offered -> 0xB2 goes to skid; occupancy=2; up_ready=0 next cycle. Raise dn_ready -> 0xA1 then 0xB2 delivered in order; up_ready=1 after 0xA1 leaves.
3. FULL, assert flush for 1 cycle with up_valid=1, up_data=0xCC -> next cycle dn_valid=0, dn_ctrl=0, dn_data=0, occupancy=0; 0xCC never appears.
4. Stage holds entry with up_ctrl=2'b11, then empties -> dn_ctrl=2'b00 on the bubble. With BUBBLE_ZERO=0, dn_data keeps the last payload while dn_ctrl is 0.
5. Assert nreset while FULL with dn_ready=0 -> after the edge all outputs 0, up_ready=1; the first post-reset entry 0x5A is delivered alone.
6. With STAGE_PERF_CNT_EN and CNT_W=4: hold dn_valid=1, dn_ready=0 for 20 cycles -> stall_cycles=15 (saturated), bubble_cycles=0; flush leaves both unchanged.
